// File: rtl/heichips25_proj_switch.sv
// heichips25_proj_switch
// Glitch-free project selector for the tiny wrapper. A select request
// holds the project reset low for DRAIN_CYCLES, flips ena_out, then keeps
// the reset low for HOLD_CYCLES more before releasing it, so the select
// line never moves while either project is running.
// Optional feature: define HEICHIPS25_SWITCH_CNT_EN to build the 8-bit
// completed-switch counter; otherwise switch_count is tied to zero.
module heichips25_proj_switch #(
    parameter int unsigned DRAIN_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ext_rst_n,
    input  logic       sel_valid,
    input  logic       sel_req,
    output logic       sel_ready,
    output logic       ena_out,
    output logic       rst_n_proj,
    output logic       busy,
    output logic [7:0] switch_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] DRAIN_LOAD = 8'(DRAIN_CYCLES);
    localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_CYCLES);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       ena_q, ena_d;
    logic       req_q, req_d;
    logic       rst_n_proj_q, rst_n_proj_d;
    logic       sel_ready_q, sel_ready_d;
    logic       busy_q, busy_d;

    // Next-state logic: one shared down-counter times both DRAIN and HOLD.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ena_d   = ena_q;
        req_d   = req_q;
        case (state_q)
            ST_IDLE: begin
                // sel_ready_q is high exactly while in IDLE, so this is the handshake.
                if (sel_valid && sel_ready_q && (sel_req != ena_q)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                    req_d   = sel_req;
                end else begin
                    cnt_d   = 8'd0;
                end
            end
            ST_DRAIN: begin
                if (cnt_q <= 8'd1) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                    ena_d   = req_q;
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q <= 8'd1) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d   = cnt_q - 8'd1;
                end
            end
            default: begin
                // Unreachable encoding: recover through a full reset hold.
                state_d = ST_HOLD;
                cnt_d   = HOLD_LOAD;
                ena_d   = 1'b0;
            end
        endcase
    end

    // Output next values are derived from the next state so every output is a flop.
    always_comb begin
        sel_ready_d  = (state_d == ST_IDLE);
        busy_d       = (state_d != ST_IDLE);
        rst_n_proj_d = (state_d == ST_IDLE) ? ext_rst_n : 1'b0;
    end

    // State, counter and output registers; reset parks in HOLD with the project held.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_HOLD;
            cnt_q        <= HOLD_LOAD;
            ena_q        <= 1'b0;
            req_q        <= 1'b0;
            rst_n_proj_q <= 1'b0;
            sel_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ena_q        <= ena_d;
            req_q        <= req_d;
            rst_n_proj_q <= rst_n_proj_d;
            sel_ready_q  <= sel_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign sel_ready  = sel_ready_q;
    assign ena_out    = ena_q;
    assign rst_n_proj = rst_n_proj_q;
    assign busy       = busy_q;

`ifdef HEICHIPS25_SWITCH_CNT_EN
    logic       switched_q;
    logic [7:0] switch_count_q;
    logic       drain_exit_s;
    logic       hold_done_s;

    assign drain_exit_s = (state_q == ST_DRAIN) && (state_d == ST_HOLD);
    assign hold_done_s  = (state_q == ST_HOLD)  && (state_d == ST_IDLE);

    // Count only HOLD exits that follow a DRAIN, so the post-reset HOLD is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            switched_q     <= 1'b0;
            switch_count_q <= 8'd0;
        end else if (drain_exit_s) begin
            switched_q     <= 1'b1;
            switch_count_q <= switch_count_q;
        end else if (hold_done_s && switched_q) begin
            switched_q     <= 1'b0;
            switch_count_q <= switch_count_q + 8'd1;
        end else begin
            switched_q     <= switched_q;
            switch_count_q <= switch_count_q;
        end
    end

    assign switch_count = switch_count_q;
`else
    assign switch_count = 8'd0;
`endif

endmodule

// File: doc/heichips25_proj_switch.md
HEICHIPS25_PROJ_SWITCH -- requirements
Module: heichips25_proj_switch

Interface
REQ-001 The block SHALL have parameter DRAIN_CYCLES, default 2, giving the cycles the project reset is held low before the select line changes; legal range 1..255.
REQ-002 The block SHALL have parameter HOLD_CYCLES, default 4, giving the cycles the project reset is held low after the select line changes; legal range 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL be updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port ext_rst_n, input, 1 bit: external active-low project reset request.
REQ-006 The block SHALL have port sel_valid, input, 1 bit: a project-select request is present.
REQ-007 The block SHALL have port sel_req, input, 1 bit: the requested project (0 = PPWM, 1 = SDR).
REQ-008 The block SHALL have port sel_ready, output, 1 bit: the block accepts a request this cycle.
REQ-009 The block SHALL have port ena_out, output, 1 bit: the project-select line driven to the tiny wrapper's ena input (0 = PPWM, 1 = SDR).
REQ-010 The block SHALL have port rst_n_proj, output, 1 bit: the active-low reset driven to the tiny wrapper's rst_n input.
REQ-011 The block SHALL have port busy, output, 1 bit: a switch sequence is in progress.
REQ-012 The block SHALL have port switch_count, output, 8 bits: the number of completed project switches.
REQ-013 All outputs SHALL be registered, with no combinational path from any input to any output.

Function
REQ-014 The state machine SHALL have exactly three states: IDLE, DRAIN and HOLD, with one 8-bit down-counter shared between DRAIN and HOLD.
REQ-015 In IDLE: sel_ready=1, busy=0, rst_n_proj=ext_rst_n delayed by one register stage.
REQ-016 A handshake SHALL be sel_valid=1 and sel_ready=1 in the same cycle.
REQ-017 A handshake with sel_req==ena_out SHALL be a no-op: state stays IDLE and there is no reset pulse.
REQ-018 A handshake in cycle T with sel_req!=ena_out SHALL move to DRAIN, and cycles T+1..T+DRAIN_CYCLES SHALL show rst_n_proj=0, busy=1, sel_ready=0, with ena_out unchanged.
REQ-019 In cycle T+DRAIN_CYCLES+1, ena_out SHALL take the latched sel_req and the state SHALL move to HOLD for HOLD_CYCLES cycles with rst_n_proj=0.
REQ-020 In cycle T+DRAIN_CYCLES+HOLD_CYCLES+1, the state SHALL return to IDLE, sel_ready=1 and rst_n_proj=ext_rst_n.
REQ-021 In DRAIN and HOLD, sel_valid and sel_req SHALL be ignored, and sel_req SHALL be latched only at the handshake.
REQ-022 rst_n_proj SHALL never be 1 in any cycle where ena_out changes, nor in the cycle before or after the change.
REQ-023 ext_rst_n=0 in any state SHALL force rst_n_proj=0 one cycle later, and SHALL NOT alter the state or timing of the sequence.
REQ-024 A handshake accepted in the same cycle the machine returns to IDLE SHALL start a new sequence immediately, with no idle gap required.

Reset
REQ-025 While rst=1: state=HOLD, counter=HOLD_CYCLES, ena_out=0, rst_n_proj=0, sel_ready=0, busy=1, switch_count=0.
REQ-026 After rst falls, the block SHALL hold rst_n_proj=0 for HOLD_CYCLES further cycles and then enter IDLE.
REQ-027 rst asserted mid-sequence SHALL abort it: ena_out returns to 0 on the next edge, and no count increment occurs.

Configuration
REQ-028 With macro HEICHIPS25_SWITCH_CNT_EN defined, switch_count SHALL increment by 1 on each HOLD to IDLE transition that follows a DRAIN, wrapping 255 to 0; the post-reset HOLD SHALL NOT count.
REQ-029 Without HEICHIPS25_SWITCH_CNT_EN, switch_count SHALL be constant 0 and no counter register SHALL be synthesized.

Verification
REQ-030 Power-up: rst=1 for 3 cycles then 0 -> rst_n_proj=0 for 4 more cycles, then 1; ena_out=0 throughout; sel_ready rises with IDLE.
REQ-031 Switch PPWM to SDR: sel_valid=1, sel_req=1 at T -> rst_n_proj low T+1..T+6; ena_out=1 from T+3; sel_ready=1 at T+7; switch_count=1 (macro defined).
REQ-032 Same-project request: ena_out=0, sel_req=0, sel_valid=1 -> rst_n_proj stays 1, busy stays 0, switch_count unchanged.
REQ-033 Abort: rst=1 at T+4 of an SDR switch -> ena_out=0 at T+5, rst_n_proj=0, switch_count unchanged, re-entry into HOLD.
REQ-034 Back-to-back plus external reset: sel_valid held high with alternating sel_req -> switches every 7 cycles; a 1-cycle ext_rst_n=0 pulse in IDLE -> 1-cycle rst_n_proj=0 one cycle later; 256 switches with the macro -> switch_count wraps to 0.
